cpu_core_mc: RTL and testbench

- Parametrised multi-cycle successor of the current single-clock soft CPU top.
- Generalises data width, register count and PC width.
- Replaces fixed-latency ROM/RAM coupling with req/ack handshakes to external instruction and data memories.
- Adds stall-tolerant fetch, a HALT state and a registered output port with a strobe.
- Sits at the top of the Prototype_Processor hierarchy; instantiated by the board wrapper alongside on-chip ROM/RAM adapters.

---
 rtl/cpu_pkg.sv | 33 +++
 rtl/cpu_regfile_mc.sv | 42 ++++
 rtl/cpu_core_mc.sv | 219 +++++++++++++++++++++
 tb/tb_cpu_core_mc.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared opcodes, flag indices and FSM states
// for the multi-cycle Prototype_Processor core.
package cpu_pkg;

  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_AND  = 4'h2;
  localparam logic [3:0] OP_OR   = 4'h3;
  localparam logic [3:0] OP_XOR  = 4'h4;
  localparam logic [3:0] OP_ADDI = 4'h5;
  localparam logic [3:0] OP_LD   = 4'h6;
  localparam logic [3:0] OP_ST   = 4'h7;
  localparam logic [3:0] OP_BEQ  = 4'h8;
  localparam logic [3:0] OP_JMP  = 4'h9;
  localparam logic [3:0] OP_OUT  = 4'hA;
  localparam logic [3:0] OP_HALT = 4'hF;

  localparam int FLAG_Z = 0;
  localparam int FLAG_N = 1;
  localparam int FLAG_C = 2;
  localparam int FLAG_V = 3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_EXEC,
    S_MEM,
    S_WB,
    S_IDLE_CHK,
    S_HALT
  } state_e;

endpackage

// File: rtl/cpu_regfile_mc.sv
// General register file: two async read ports,
// one write port, R0 hard-wired to zero.
module cpu_regfile_mc #(
  parameter int DATA_W = 32,
  parameter int NREGS  = 16,
  parameter int AW     = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     ra1,
  input  logic [AW-1:0]     ra2,
  output logic [DATA_W-1:0] rd1,
  output logic [DATA_W-1:0] rd2
);

  logic [DATA_W-1:0] regs_q [NREGS];
  logic [DATA_W-1:0] regs_d [NREGS];

  always_comb begin
    regs_d = regs_q;
    if (we && (waddr != '0)) begin
      regs_d[waddr] = wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      regs_q <= regs_d;
    end
  end

  assign rd1 = (ra1 == '0) ? '0 : regs_q[ra1];
  assign rd2 = (ra2 == '0) ? '0 : regs_q[ra2];

endmodule

// File: rtl/cpu_core_mc.sv
// Multi-cycle soft CPU with req/ack instruction
// and data memories, HALT state and strobed output.
module cpu_core_mc
  import cpu_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int NREGS   = 16,
  parameter int PC_W    = 10,
  parameter int DADDR_W = 10
) (
  input  logic               CLK,
  input  logic               ASYN_CLR_N,
  input  logic               CPU_EN,
  output logic               IMEM_REQ,
  output logic [PC_W-1:0]    IMEM_ADDR,
  input  logic               IMEM_ACK,
  input  logic [31:0]        IMEM_RDATA,
  output logic               DMEM_REQ,
  output logic               DMEM_WE,
  output logic [DADDR_W-1:0] DMEM_ADDR,
  output logic [DATA_W-1:0]  DMEM_WDATA,
  input  logic               DMEM_ACK,
  input  logic [DATA_W-1:0]  DMEM_RDATA,
  output logic [PC_W-1:0]    PC_OUT,
  output logic [3:0]         FLAG_OUT,
  output logic [DATA_W-1:0]  OUT_RESULT,
  output logic               DOUT,
  output logic               HALTED
);

  localparam int AW = (NREGS > 1) ? $clog2(NREGS) : 1;
  localparam int M  = DATA_W - 1;

  state_e            state_q, state_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic [31:0]       ir_q, ir_d;
  logic [3:0]        flags_q, flags_d;
  logic [DATA_W-1:0] res_q, res_d;
  logic [DATA_W-1:0] out_q, out_d;
  logic              dout_q, dout_d;

  logic [3:0]        op;
  logic [AW-1:0]     rd_a, rs_a, rt_a;
  logic [DATA_W-1:0] rs_v, rt_v, imm, opb;
  logic [PC_W-1:0]   pc_imm, pc_inc;
  logic [DATA_W:0]   sum_c, diff_c;
  logic [DATA_W-1:0] alu_res;
  logic [3:0]        alu_flags;
  logic              alu_c, alu_v;
  logic              is_alu, is_ldst;
  logic              mem_phase;
  state_e            nxt;

  assign op     = ir_q[31:28];
  assign rd_a   = ir_q[24 +: AW];
  assign rs_a   = ir_q[20 +: AW];
  assign rt_a   = ir_q[16 +: AW];
  assign imm    = DATA_W'($signed(ir_q[15:0]));
  assign pc_imm = PC_W'($signed(ir_q[15:0]));
  assign pc_inc = pc_q + PC_W'(1);

  assign is_alu  = (op <= OP_ADDI);
  assign is_ldst = (op == OP_LD) || (op == OP_ST);

  cpu_regfile_mc #(
    .DATA_W (DATA_W),
    .NREGS  (NREGS),
    .AW     (AW)
  ) u_rf (
    .clk   (CLK),
    .rst_n (ASYN_CLR_N),
    .we    (state_q == S_WB),
    .waddr (rd_a),
    .wdata (res_q),
    .ra1   (rs_a),
    .ra2   (rt_a),
    .rd1   (rs_v),
    .rd2   (rt_v)
  );

  // Immediate forms share the adder with address generation.
  assign opb    = (op == OP_ADDI || is_ldst) ? imm : rt_v;
  assign sum_c  = {1'b0, rs_v} + {1'b0, opb};
  assign diff_c = {1'b0, rs_v} + {1'b0, ~opb} + (DATA_W+1)'(1);

  always_comb begin
    alu_res = sum_c[M:0];
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    case (op)
      OP_ADD, OP_ADDI: begin
        alu_res = sum_c[M:0];
        alu_c   = sum_c[DATA_W];
        alu_v   = (rs_v[M] == opb[M]) &&
                  (sum_c[M] != rs_v[M]);
      end
      OP_SUB: begin
        alu_res = diff_c[M:0];
        alu_c   = diff_c[DATA_W];
        alu_v   = (rs_v[M] != opb[M]) &&
                  (diff_c[M] != rs_v[M]);
      end
      OP_AND:  alu_res = rs_v & rt_v;
      OP_OR:   alu_res = rs_v | rt_v;
      OP_XOR:  alu_res = rs_v ^ rt_v;
      default: alu_res = sum_c[M:0];
    endcase
    alu_flags         = '0;
    alu_flags[FLAG_Z] = (alu_res == '0);
    alu_flags[FLAG_N] = alu_res[M];
    alu_flags[FLAG_C] = alu_c;
    alu_flags[FLAG_V] = alu_v;
  end

  assign mem_phase = (state_q == S_MEM) ||
                     (state_q == S_EXEC && is_ldst);
  assign nxt = CPU_EN ? S_FETCH : S_IDLE;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    flags_d = flags_q;
    res_d   = res_q;
    out_d   = out_q;
    dout_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (CPU_EN) state_d = S_FETCH;
      end
      S_FETCH: begin
        if (IMEM_ACK) begin
          ir_d    = IMEM_RDATA;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        unique case (1'b1)
          is_alu: begin
            res_d   = alu_res;
            flags_d = alu_flags;
            state_d = S_WB;
          end
          is_ldst: state_d = S_MEM;
          (op == OP_BEQ): begin
            pc_d    = (rs_v == rt_v) ? pc_inc + pc_imm : pc_inc;
            state_d = nxt;
          end
          (op == OP_JMP): begin
            pc_d    = pc_imm;
            state_d = nxt;
          end
          (op == OP_OUT): begin
            out_d   = rs_v;
            dout_d  = 1'b1;
            pc_d    = pc_inc;
            state_d = nxt;
          end
          (op == OP_HALT): state_d = S_HALT;
          default: begin
            pc_d    = pc_inc;
            state_d = nxt;
          end
        endcase
      end
      S_WB: begin
        pc_d    = pc_inc;
        state_d = nxt;
      end
      S_IDLE_CHK: state_d = nxt;
      S_MEM:      state_d = S_MEM;
      S_HALT:     state_d = S_HALT;
      default:    state_d = S_IDLE;
    endcase
    // A zero-wait ack completes the access in the EXEC cycle.
    if (mem_phase && DMEM_ACK) begin
      if (op == OP_LD) begin
        res_d   = DMEM_RDATA;
        state_d = S_WB;
      end else begin
        pc_d    = pc_inc;
        state_d = nxt;
      end
    end
  end

  always_ff @(posedge CLK or negedge ASYN_CLR_N) begin
    if (!ASYN_CLR_N) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      ir_q    <= '0;
      flags_q <= '0;
      res_q   <= '0;
      out_q   <= '0;
      dout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      flags_q <= flags_d;
      res_q   <= res_d;
      out_q   <= out_d;
      dout_q  <= dout_d;
    end
  end

  assign IMEM_REQ   = (state_q == S_FETCH);
  assign IMEM_ADDR  = pc_q;
  assign DMEM_REQ   = mem_phase;
  assign DMEM_WE    = mem_phase && (op == OP_ST);
  assign DMEM_ADDR  = DADDR_W'(sum_c[M:0]);
  assign DMEM_WDATA = rt_v;
  assign PC_OUT     = pc_q;
  assign FLAG_OUT   = flags_q;
  assign OUT_RESULT = out_q;
  assign DOUT       = dout_q;
  assign HALTED     = (state_q == S_HALT);

endmodule

// File: tb/tb_cpu_core_mc.sv
// Directed-vector bench for cpu_core_mc with
// req/ack memory models and programmable wait states.
module tb_cpu_core_mc;

  localparam int DW = 16;

  logic          CLK = 1'b0;
  logic          ASYN_CLR_N = 1'b0;
  logic          CPU_EN = 1'b0;
  logic          IMEM_REQ, IMEM_ACK;
  logic [9:0]    IMEM_ADDR;
  logic [31:0]   IMEM_RDATA;
  logic          DMEM_REQ, DMEM_WE, DMEM_ACK;
  logic [9:0]    DMEM_ADDR;
  logic [DW-1:0] DMEM_WDATA, DMEM_RDATA;
  logic [9:0]    PC_OUT;
  logic [3:0]    FLAG_OUT;
  logic [DW-1:0] OUT_RESULT;
  logic          DOUT, HALTED;

  logic [31:0]   imem [1024];
  logic [DW-1:0] dmem [1024];
  int imem_wait = 0;
  int dmem_wait = 0;
  int icnt = 0;
  int dcnt = 0;
  int cyc = 0;
  int nfetch = 0;
  int n_vec = 0;
  int n_err = 0;
  logic          d_hold = 1'b0;
  logic [9:0]    d_addr0;
  logic [DW-1:0] d_wd0;

  cpu_core_mc #(
    .DATA_W (DW),
    .NREGS  (16),
    .PC_W   (10),
    .DADDR_W(10)
  ) dut (
    .CLK       (CLK),
    .ASYN_CLR_N(ASYN_CLR_N),
    .CPU_EN    (CPU_EN),
    .IMEM_REQ  (IMEM_REQ),
    .IMEM_ADDR (IMEM_ADDR),
    .IMEM_ACK  (IMEM_ACK),
    .IMEM_RDATA(IMEM_RDATA),
    .DMEM_REQ  (DMEM_REQ),
    .DMEM_WE   (DMEM_WE),
    .DMEM_ADDR (DMEM_ADDR),
    .DMEM_WDATA(DMEM_WDATA),
    .DMEM_ACK  (DMEM_ACK),
    .DMEM_RDATA(DMEM_RDATA),
    .PC_OUT    (PC_OUT),
    .FLAG_OUT  (FLAG_OUT),
    .OUT_RESULT(OUT_RESULT),
    .DOUT      (DOUT),
    .HALTED    (HALTED)
  );

  always #5 CLK = ~CLK;

  assign IMEM_RDATA = imem[IMEM_ADDR];
  assign DMEM_RDATA = dmem[DMEM_ADDR];
  assign IMEM_ACK   = IMEM_REQ && (icnt >= imem_wait);
  assign DMEM_ACK   = DMEM_REQ && (dcnt >= dmem_wait);

  always @(posedge CLK) begin
    cyc  <= cyc + 1;
    icnt <= (IMEM_REQ && !IMEM_ACK) ? icnt + 1 : 0;
    dcnt <= (DMEM_REQ && !DMEM_ACK) ? dcnt + 1 : 0;
    if (IMEM_REQ && IMEM_ACK) nfetch <= nfetch + 1;
    if (DMEM_REQ && DMEM_WE && DMEM_ACK)
      dmem[DMEM_ADDR] <= DMEM_WDATA;
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Data request inputs must not move while waiting for ack.
  always @(negedge CLK) begin
    if (DMEM_REQ) begin
      if (d_hold) begin
        chk("dmem_addr_hold", 32'(DMEM_ADDR), 32'(d_addr0));
        chk("dmem_wdata_hold", 32'(DMEM_WDATA), 32'(d_wd0));
      end
      d_addr0 <= DMEM_ADDR;
      d_wd0   <= DMEM_WDATA;
      d_hold  <= !DMEM_ACK;
    end else begin
      d_hold <= 1'b0;
    end
  end

  task automatic load_clear();
    for (int i = 0; i < 1024; i++) begin
      imem[i] = 32'hF000_0000;
      dmem[i] = '0;
    end
  endtask

  task automatic do_reset(input logic en);
    ASYN_CLR_N = 1'b0;
    CPU_EN = en;
    repeat (2) @(negedge CLK);
    ASYN_CLR_N = 1'b1;
  endtask

  task automatic wait_pc(input string tag, input logic [9:0] t);
    for (int i = 0; i < 300; i++) begin
      if (PC_OUT == t) break;
      @(negedge CLK);
    end
    chk(tag, 32'(PC_OUT), 32'(t));
  endtask

  task automatic wait_dout(input string tag);
    for (int i = 0; i < 300; i++) begin
      if (DOUT) break;
      @(negedge CLK);
    end
    chk(tag, 32'(DOUT), 32'd1);
  endtask

  int c0;
  int f0;

  initial begin
    // ---- reset state ----
    load_clear();
    imem[0] = 32'h5100_0005;
    imem[1] = 32'h5200_FFFD;
    imem[2] = 32'h0312_0000;
    imem[3] = 32'hA030_0000;
    imem[4] = 32'hF000_0000;
    ASYN_CLR_N = 1'b0;
    CPU_EN = 1'b1;
    repeat (2) @(negedge CLK);
    chk("rst_pc", 32'(PC_OUT), 0);
    chk("rst_ireq", 32'(IMEM_REQ), 0);
    chk("rst_dreq", 32'(DMEM_REQ), 0);
    chk("rst_flags", 32'(FLAG_OUT), 0);
    chk("rst_out", 32'(OUT_RESULT), 0);
    chk("rst_halt", 32'(HALTED), 0);
    ASYN_CLR_N = 1'b1;

    // ---- ADDI/ADDI/ADD/OUT ----
    for (int i = 0; i < 20; i++) begin
      if (IMEM_REQ) break;
      @(negedge CLK);
    end
    c0 = cyc;
    wait_dout("p1_dout");
    chk("p1_latency", cyc - c0, 11);
    chk("p1_out", 32'(OUT_RESULT), 2);
    chk("p1_flags", 32'(FLAG_OUT), 32'b0100);
    @(negedge CLK);
    chk("p1_dout_pulse", 32'(DOUT), 0);
    repeat (6) @(negedge CLK);
    chk("p1_halted", 32'(HALTED), 1);
    chk("p1_halt_pc", 32'(PC_OUT), 4);
    chk("p1_halt_noreq", 32'(IMEM_REQ), 0);

    // ---- flags, store/load with wait states ----
    load_clear();
    imem[0] = 32'h5100_0007;
    imem[1] = 32'h1611_0000;
    imem[2] = 32'h5400_7FFF;
    imem[3] = 32'h0744_0000;
    imem[4] = 32'hA070_0000;
    imem[5] = 32'h7001_003F;
    imem[6] = 32'h6500_003F;
    imem[7] = 32'hA050_0000;
    imem[8] = 32'hF000_0000;
    dmem_wait = 4;
    do_reset(1'b1);
    wait_pc("p2_pc2", 10'd2);
    chk("p2_sub_flags", 32'(FLAG_OUT), 32'b0101);
    wait_pc("p2_pc4", 10'd4);
    chk("p2_ovf_flags", 32'(FLAG_OUT), 32'b1010);
    wait_dout("p2_dout_a");
    chk("p2_out_sum", 32'(OUT_RESULT), 32'hFFFE);
    wait_pc("p2_pc6", 10'd6);
    chk("p2_stored", 32'(dmem[10'h3F]), 7);
    wait_dout("p2_dout_b");
    chk("p2_out_ld", 32'(OUT_RESULT), 7);
    chk("p2_pc_after_ld", 32'(PC_OUT), 8);
    repeat (4) @(negedge CLK);
    chk("p2_halted", 32'(HALTED), 1);
    chk("p2_halt_pc", 32'(PC_OUT), 8);
    dmem_wait = 0;

    // ---- BEQ self-loop ----
    load_clear();
    imem[0] = 32'h8000_FFFF;
    do_reset(1'b1);
    f0 = nfetch;
    repeat (20) @(negedge CLK);
    chk("beq_pc", 32'(PC_OUT), 0);
    chk("beq_fetches", 32'((nfetch - f0) >= 8), 1);

    // ---- JMP to top of PC space, wrap ----
    load_clear();
    imem[0] = 32'h9000_03FF;
    imem[10'h3FF] = 32'hB000_0000;
    do_reset(1'b1);
    wait_pc("jmp_top", 10'h3FF);
    wait_pc("jmp_wrap", 10'h000);
    chk("jmp_halt", 32'(HALTED), 0);

    // ---- CPU_EN drop in stalled fetch ----
    load_clear();
    imem[0] = 32'h5100_0001;
    imem[1] = 32'h5111_0001;
    imem[2] = 32'hA010_0000;
    imem_wait = 3;
    do_reset(1'b1);
    for (int i = 0; i < 100; i++) begin
      if (IMEM_REQ && PC_OUT == 10'd1) break;
      @(negedge CLK);
    end
    chk("en_stall_seen", 32'(IMEM_REQ), 1);
    CPU_EN = 1'b0;
    repeat (15) @(negedge CLK);
    chk("en_park_pc", 32'(PC_OUT), 2);
    chk("en_park_noreq", 32'(IMEM_REQ), 0);
    CPU_EN = 1'b1;
    wait_dout("en_resume_dout");
    chk("en_resume_out", 32'(OUT_RESULT), 2);
    imem_wait = 0;

    // ---- reset in the middle of a store ----
    load_clear();
    imem[0] = 32'h5100_0009;
    imem[1] = 32'h7001_0010;
    imem[2] = 32'hA010_0000;
    dmem[10'h10] = 16'h1234;
    dmem_wait = 6;
    do_reset(1'b1);
    for (int i = 0; i < 50; i++) begin
      if (DMEM_REQ) break;
      @(negedge CLK);
    end
    chk("mrst_in_mem", 32'(DMEM_REQ), 1);
    repeat (2) @(negedge CLK);
    #2 ASYN_CLR_N = 1'b0;
    CPU_EN = 1'b0;
    #1;
    chk("mrst_dreq", 32'(DMEM_REQ), 0);
    chk("mrst_dwe", 32'(DMEM_WE), 0);
    chk("mrst_pc", 32'(PC_OUT), 0);
    chk("mrst_halt", 32'(HALTED), 0);
    repeat (3) @(negedge CLK);
    ASYN_CLR_N = 1'b1;
    repeat (8) @(negedge CLK);
    chk("mrst_nowrite", 32'(dmem[10'h10]), 32'h1234);
    chk("mrst_idle_pc", 32'(PC_OUT), 0);
    chk("mrst_idle_ireq", 32'(IMEM_REQ), 0);
    chk("mrst_out", 32'(OUT_RESULT), 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
